// File: rtl/fb_branch_predictor.sv
// Dynamic branch predictor/resolver: direct-mapped BHT/BTB of 2-bit saturating
// counters, IF-stage lookup, MEM-stage resolve, training and mispredict count.
module fb_branch_predictor #(
  parameter int XLEN      = 32,
  parameter int BHT_DEPTH = 64,
  parameter int TAG_W     = 8,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [XLEN-1:0]  pc,
  output logic             predict_taken,
  output logic [XLEN-1:0]  predict_pc,
  input  logic             res_valid,
  input  logic [XLEN-1:0]  res_pc,
  input  logic [2:0]       res_funct3,
  input  logic [XLEN-1:0]  res_target,
  input  logic             res_pred_taken,
  input  logic [XLEN-1:0]  res_pred_pc,
  input  logic             NF,
  input  logic             ZF,
  input  logic             CF,
  input  logic             VF,
  output logic             mispredict,
  output logic [XLEN-1:0]  redirect_pc,
  output logic [CNT_W-1:0] mispredict_cnt
);

  localparam int IDX_W = $clog2(BHT_DEPTH);

  logic             valid_q  [BHT_DEPTH];
  logic [TAG_W-1:0] tag_q    [BHT_DEPTH];
  logic [XLEN-1:0]  target_q [BHT_DEPTH];
  logic [1:0]       ctr_q    [BHT_DEPTH];
  logic [CNT_W-1:0] cnt_q;

  logic [IDX_W-1:0] idx, res_idx;
  logic [TAG_W-1:0] tag, res_tag;
  logic             hit, res_hit;
  logic             type_ok, actual_taken, update_en;

  assign idx     = pc[IDX_W+1:2];
  assign tag     = pc[IDX_W+TAG_W+1:IDX_W+2];
  assign res_idx = res_pc[IDX_W+1:2];
  assign res_tag = res_pc[IDX_W+TAG_W+1:IDX_W+2];

  assign hit     = valid_q[idx] && (tag_q[idx] == tag);
  assign res_hit = valid_q[res_idx] && (tag_q[res_idx] == res_tag);

  // Lookup reads the registered table, so a same-cycle update is not bypassed.
  assign predict_taken = hit && ctr_q[idx][1];
  assign predict_pc    = predict_taken ? target_q[idx] : pc + XLEN'(4);

  always_comb begin
    type_ok      = 1'b1;
    actual_taken = 1'b0;
    case (res_funct3)
      3'b000:  actual_taken = ZF;
      3'b001:  actual_taken = !ZF;
      3'b100:  actual_taken = NF ^ VF;
      3'b101:  actual_taken = !(NF ^ VF);
      3'b110:  actual_taken = CF;
      3'b111:  actual_taken = !CF;
      default: type_ok = 1'b0;
    endcase
  end

  assign update_en   = res_valid && type_ok;
  assign mispredict  = update_en &&
                       ((actual_taken != res_pred_taken) ||
                        (actual_taken && res_pred_taken && (res_target != res_pred_pc)));
  assign redirect_pc = actual_taken ? res_target : res_pc + XLEN'(4);

  assign mispredict_cnt = cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BHT_DEPTH; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= 2'b01;
      end
      cnt_q <= '0;
    end else begin
      if (update_en) begin
        if (res_hit) begin
          if (actual_taken && ctr_q[res_idx] != 2'b11)
            ctr_q[res_idx] <= ctr_q[res_idx] + 2'd1;
          else if (!actual_taken && ctr_q[res_idx] != 2'b00)
            ctr_q[res_idx] <= ctr_q[res_idx] - 2'd1;
        end else if (actual_taken) begin
          valid_q[res_idx] <= 1'b1;
          ctr_q[res_idx]   <= 2'b10;
        end
      end
      if (mispredict && cnt_q != {CNT_W{1'b1}})
        cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Tag/target carry no reset; valid gates them. Writing the tag on a taken hit is harmless.
  always_ff @(posedge clk) begin
    if (update_en && actual_taken) begin
      tag_q[res_idx]    <= res_tag;
      target_q[res_idx] <= res_target;
    end
  end

endmodule

// File: tb/tb_fb_branch_predictor.sv
// Self-checking bench for fb_branch_predictor: directed steps plus randomized
// traffic checked against a behavioural table model.
module tb_fb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc;
  logic        res_valid;
  logic [31:0] res_pc;
  logic [2:0]  res_funct3;
  logic [31:0] res_target;
  logic        res_pred_taken;
  logic [31:0] res_pred_pc;
  logic        NF, ZF, CF, VF;

  logic        predict_taken, mispredict;
  logic [31:0] predict_pc, redirect_pc;
  logic [15:0] mispredict_cnt;

  logic        predict_taken2, mispredict2;
  logic [31:0] predict_pc2, redirect_pc2;
  logic [1:0]  mispredict_cnt2;

  int compared   = 0;
  int mismatched = 0;

  // reference model state
  bit          m_valid  [64];
  logic [7:0]  m_tag    [64];
  logic [31:0] m_target [64];
  int          m_ctr    [64];
  int          m_cnt16;
  int          m_cnt2;

  always #5 clk = ~clk;

  fb_branch_predictor dut (
    .clk(clk), .rst(rst), .pc(pc),
    .predict_taken(predict_taken), .predict_pc(predict_pc),
    .res_valid(res_valid), .res_pc(res_pc), .res_funct3(res_funct3),
    .res_target(res_target), .res_pred_taken(res_pred_taken), .res_pred_pc(res_pred_pc),
    .NF(NF), .ZF(ZF), .CF(CF), .VF(VF),
    .mispredict(mispredict), .redirect_pc(redirect_pc), .mispredict_cnt(mispredict_cnt)
  );

  fb_branch_predictor #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .pc(pc),
    .predict_taken(predict_taken2), .predict_pc(predict_pc2),
    .res_valid(res_valid), .res_pc(res_pc), .res_funct3(res_funct3),
    .res_target(res_target), .res_pred_taken(res_pred_taken), .res_pred_pc(res_pred_pc),
    .NF(NF), .ZF(ZF), .CF(CF), .VF(VF),
    .mispredict(mispredict2), .redirect_pc(redirect_pc2), .mispredict_cnt(mispredict_cnt2)
  );

  function automatic int idxOf(logic [31:0] a);
    return int'((a >> 2) % 64);
  endfunction

  function automatic logic [7:0] tagOf(logic [31:0] a);
    return 8'((a >> 8) % 256);
  endfunction

  function automatic bit modelHit(logic [31:0] a);
    return m_valid[idxOf(a)] && (m_tag[idxOf(a)] == tagOf(a));
  endfunction

  function automatic bit modelPredTaken(logic [31:0] a);
    return modelHit(a) && (m_ctr[idxOf(a)] >= 2);
  endfunction

  function automatic logic [31:0] modelPredPc(logic [31:0] a);
    return modelPredTaken(a) ? m_target[idxOf(a)] : a + 32'd4;
  endfunction

  // Branch outcome from the flags of rs1-rs2; ok=0 for the reserved funct3 codes.
  function automatic void branchOutcome(input logic [2:0] f3, output bit ok, output bit taken);
    ok = 1; taken = 0;
    case (f3)
      3'd0: taken = ZF;
      3'd1: taken = !ZF;
      3'd4: taken = NF != VF;
      3'd5: taken = NF == VF;
      3'd6: taken = CF;
      3'd7: taken = !CF;
      default: ok = 0;
    endcase
  endfunction

  function automatic void modelReset();
    for (int i = 0; i < 64; i++) begin
      m_valid[i] = 0;
      m_ctr[i]   = 1;
    end
    m_cnt16 = 0;
    m_cnt2  = 0;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  // Inputs are set just after a falling edge; check, clock, then train the model.
  task automatic applyStimulus();
    bit ok, taken, exp_mis, hit_r;
    int ri;
    #1;
    branchOutcome(res_funct3, ok, taken);
    exp_mis = res_valid && ok &&
              ((taken != res_pred_taken) || (taken && res_pred_taken && res_target != res_pred_pc));
    checkOutput("predict_taken", 32'(predict_taken), 32'(modelPredTaken(pc)));
    checkOutput("predict_pc", predict_pc, modelPredPc(pc));
    checkOutput("mispredict", 32'(mispredict), 32'(exp_mis));
    if (exp_mis)
      checkOutput("redirect_pc", redirect_pc, taken ? res_target : res_pc + 32'd4);
    checkOutput("mispredict_cnt", 32'(mispredict_cnt), 32'(m_cnt16));
    checkOutput("mispredict_cnt2", 32'(mispredict_cnt2), 32'(m_cnt2));
    hit_r = modelHit(res_pc);
    ri    = idxOf(res_pc);
    @(posedge clk);
    if (res_valid && ok) begin
      if (hit_r) begin
        if (taken) begin
          m_ctr[ri]    = (m_ctr[ri] < 3) ? m_ctr[ri] + 1 : 3;
          m_target[ri] = res_target;
        end else begin
          m_ctr[ri] = (m_ctr[ri] > 0) ? m_ctr[ri] - 1 : 0;
        end
      end else if (taken) begin
        m_valid[ri]  = 1;
        m_tag[ri]    = tagOf(res_pc);
        m_target[ri] = res_target;
        m_ctr[ri]    = 2;
      end
    end
    if (exp_mis) begin
      if (m_cnt16 < 65535) m_cnt16++;
      if (m_cnt2 < 3) m_cnt2++;
    end
    @(negedge clk);
  endtask

  task automatic setResolve(input logic v, input logic [31:0] rpc, input logic [2:0] f3,
                            input logic [31:0] tgt, input logic pt, input logic [31:0] ppc,
                            input logic [3:0] nzcv);
    res_valid = v; res_pc = rpc; res_funct3 = f3; res_target = tgt;
    res_pred_taken = pt; res_pred_pc = ppc;
    {NF, ZF, CF, VF} = nzcv;
  endtask

  task automatic idle(input logic [31:0] fetch);
    pc = fetch;
    setResolve(1'b0, 32'h0, 3'd0, 32'h0, 1'b0, 32'h0, 4'h0);
    applyStimulus();
  endtask

  // Called just after a falling edge; reset effects must appear before any clock edge.
  task automatic resetMidStream(input logic [31:0] discard_pc);
    setResolve(1'b1, discard_pc, 3'd0, 32'h500, 1'b0, discard_pc + 32'd4, 4'b0100);
    rst = 1'b1;
    modelReset();
    for (int k = 0; k < 3; k++) begin
      pc = (k == 0) ? discard_pc : 32'h100 + 32'(k) * 32'h100;
      #1;
      checkOutput("rst_predict_taken", 32'(predict_taken), 32'd0);
      checkOutput("rst_predict_pc", predict_pc, pc + 32'd4);
      checkOutput("rst_cnt", 32'(mispredict_cnt), 32'd0);
      checkOutput("rst_cnt2", 32'(mispredict_cnt2), 32'd0);
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [31:0] rp, fp;
    rst = 1'b1;
    pc  = 32'h0;
    setResolve(1'b0, 32'h0, 3'd0, 32'h0, 1'b0, 32'h0, 4'h0);
    modelReset();
    repeat (2) @(negedge clk);
    rst = 1'b0;

    $display("[TB] reset state");
    idle(32'h100);

    $display("[TB] bge allocate at 0x100");
    pc = 32'h100;
    setResolve(1'b1, 32'h100, 3'b101, 32'h80, 1'b0, 32'h104, 4'b0000);
    applyStimulus();
    idle(32'h100);

    $display("[TB] beq not-taken x3 at 0x100");
    for (int k = 0; k < 3; k++) begin
      pc = 32'h100;
      setResolve(1'b1, 32'h100, 3'b000, 32'h80, modelPredTaken(32'h100),
                 modelPredPc(32'h100), 4'b0000);
      applyStimulus();
    end
    idle(32'h100);

    $display("[TB] aliasing at idx 0");
    idle(32'h200);
    pc = 32'h200;
    setResolve(1'b1, 32'h200, 3'b000, 32'h300, 1'b0, 32'h204, 4'b0100);
    applyStimulus();
    idle(32'h100);
    idle(32'h200);
    pc = 32'h100;
    setResolve(1'b1, 32'h200, 3'b000, 32'h300, 1'b1, 32'h280, 4'b0100);
    applyStimulus();

    $display("[TB] same-cycle lookup and update");
    pc = 32'h200;
    setResolve(1'b1, 32'h200, 3'b001, 32'h340, 1'b1, 32'h300, 4'b0000);
    applyStimulus();
    idle(32'h200);
    pc = 32'h200;
    setResolve(1'b1, 32'h200, 3'b010, 32'h900, 1'b0, 32'h204, 4'b0100);
    applyStimulus();
    pc = 32'h200;
    setResolve(1'b1, 32'h200, 3'b011, 32'h900, 1'b0, 32'h204, 4'b0100);
    applyStimulus();
    idle(32'h200);

    $display("[TB] pc wrap");
    pc = 32'hFFFF_FFFC;
    setResolve(1'b1, 32'hFFFF_FFFC, 3'b110, 32'h40, 1'b1, 32'h40, 4'b0000);
    applyStimulus();

    $display("[TB] randomized traffic");
    for (int n = 0; n < 400; n++) begin
      fp = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 3)) << 2) |
           ($urandom & 32'hFFFF_0000);
      rp = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 3)) << 2) |
           ($urandom & 32'hFFFF_0000);
      pc = fp;
      if ($urandom_range(0, 9) < 7)
        setResolve(1'($urandom_range(0, 3) != 0), rp, 3'($urandom), $urandom & 32'hFFFF_FFFC,
                   modelPredTaken(rp), modelPredPc(rp), 4'($urandom));
      else
        setResolve(1'($urandom), rp, 3'($urandom), $urandom & 32'hFFFF_FFFC,
                   1'($urandom), $urandom & 32'hFFFF_FFFC, 4'($urandom));
      applyStimulus();
    end

    $display("[TB] narrow counter saturation");
    resetMidStream(32'h600);
    idle(32'h600);
    for (int k = 0; k < 4; k++) begin
      pc = 32'h100;
      setResolve(1'b1, 32'h1000 + 32'(k) * 32'h4, 3'b101, 32'h80, 1'b1, 32'h80, 4'b1000);
      applyStimulus();
    end
    idle(32'h100);

    $display("[TB] reset mid-stream");
    pc = 32'h100;
    setResolve(1'b1, 32'h100, 3'b000, 32'h180, 1'b0, 32'h104, 4'b0100);
    applyStimulus();
    idle(32'h100);
    resetMidStream(32'h700);
    idle(32'h700);
    idle(32'h100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/fb_branch_predictor.md
Name: fb_branch_predictor

Overview:
Dynamic branch predictor and resolver for the Firebird pipeline. It replaces static branch prediction with a parametrised, direct-mapped branch history/target table (BHT/BTB) of 2-bit saturating counters.
- IF stage: the block predicts combinationally from the fetch pc.
- MEM stage: the block resolves the conditional branch from the NZCV flags, flags a mispredict, supplies the redirect pc and trains the table on the clock edge.
- A saturating mispredict counter is provided for performance monitoring.

Parameters:
XLEN, 32, datapath/pc width
BHT_DEPTH, 64, table entries; power of two, >= 2; IDX_W = log2(BHT_DEPTH)
TAG_W, 8, tag bits per entry; IDX_W+TAG_W+2 <= XLEN
CNT_W, 16, mispredict counter width

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
pc  in  XLEN  IF-stage fetch pc
predict_taken  out  1  IF prediction: taken
predict_pc  out  XLEN  IF next pc
res_valid  in  1  MEM stage holds a conditional branch
res_pc  in  XLEN  pc of resolving branch
res_funct3  in  3  branch type (RV32I B-type funct3)
res_target  in  XLEN  computed branch target (res_pc+imm)
res_pred_taken  in  1  prediction carried down the pipeline for this branch
res_pred_pc  in  XLEN  predicted next pc carried down the pipeline
NF, ZF, CF, VF  in  1 each  flags of rs1-rs2; CF=1 means unsigned borrow (rs1<rs2)
mispredict  out  1  flush request for IF/ID/EX registers
redirect_pc  out  XLEN  correct next pc when mispredict=1
mispredict_cnt  out  CNT_W  saturating count of mispredicts

Behaviour:
- Indexing: idx = pc[IDX_W+1:2]; tag = pc[IDX_W+TAG_W+1:IDX_W+2]. The same mapping applies to res_pc.
- Entry state: valid (1), tag (TAG_W), target (XLEN), ctr (2).
- Reset (async): all valid=0, all ctr=2'b01, mispredict_cnt=0. Targets and tags need no reset.
- Lookup is combinational with zero latency:
  - hit = valid[idx] && tag[idx]==tag(pc).
  - predict_taken = hit && ctr[idx][1].
  - predict_pc = predict_taken ? target[idx] : pc+4.
  - After reset: predict_taken=0 and predict_pc=pc+4.
- Condition evaluation (combinational), giving actual_taken:
  - 000 beq: ZF
  - 001 bne: !ZF
  - 100 blt: NF^VF
  - 101 bge: !(NF^VF)
  - 110 bltu: CF
  - 111 bgeu: !CF
  - 010/011: invalid; the resolve is ignored (no update, mispredict=0).
- mispredict is combinational and asserts when res_valid is high, the type is valid, and either:
  - actual_taken != res_pred_taken, or
  - actual_taken && res_pred_taken && res_target != res_pred_pc.
- redirect_pc = actual_taken ? res_target : res_pc+4. The value is meaningful only while mispredict=1.
- Table update happens on the rising edge when res_valid is high and the type is valid:
  - Hit on res_pc, taken: ctr saturating +1 (max 11); target <= res_target.
  - Hit on res_pc, not taken: ctr saturating -1 (min 00).
  - Miss, taken: allocate/replace the entry with valid=1, tag, target=res_target, ctr=2'b10.
  - Miss, not taken: no change.
- mispredict_cnt increments on each edge where mispredict=1 and saturates at all-ones; it never wraps.
- Simultaneous lookup and update on the same idx: the lookup returns the pre-update entry (no bypass). The new state is visible from the next cycle.
- pc+4 and res_pc+4 wrap modulo 2^XLEN.
- Reset asserted mid-operation clears the table immediately, without waiting for a clock edge. A resolve in the same cycle as reset is discarded.
- The block does not stall. Flushing is the pipeline's job, driven by mispredict.

Test Plan:
Default parameters apply unless stated. pc 0x100 maps to idx 0, tag 1; pc 0x200 maps to idx 0, tag 2.
1. Reset, then pc=0x100 -> predict_taken=0, predict_pc=0x104, mispredict=0, mispredict_cnt=0.
2. Resolve bge (funct3 101) at 0x100 with NF=0, VF=0, target 0x80, res_pred_taken=0 -> mispredict=1, redirect_pc=0x80. Next cycle pc=0x100 -> predict_taken=1, predict_pc=0x80; mispredict_cnt=1.
3. From the state after test 2 (ctr=10), resolve beq at 0x100 with ZF=0 three times:
   - ctr goes 10 -> 01 -> 00 -> 00.
   - predict_taken=0 after the first update.
   - With res_pred_taken matching each prediction, mispredict is 1 only on the first resolve.
4. Aliasing:
   - pc=0x200 with entry 0 holding tag 1 -> miss, predict_pc=0x204.
   - A taken resolve at 0x200 (target 0x300) replaces the entry; then pc=0x100 misses and pc=0x200 predicts 0x300.
   - Correct-direction but wrong-target case: res_pred_taken=1, res_pred_pc=0x280, actual target 0x300 -> mispredict=1.
5. Same-cycle lookup and update at idx 0 -> predict output shows the old entry that cycle and the new entry the following cycle. funct3=010 with res_valid=1 -> no update, mispredict=0.
6. With CNT_W=2, force 4 mispredicts -> mispredict_cnt reads 1, 2, 3, 3. Assert rst mid-stream -> count=0 and all predictions not-taken immediately.
